// File: rtl/vx_gpu_pkg.sv
// Shared types and sizing helpers for the dispatch path.
package vx_gpu_pkg;

   localparam int DISPATCH_PID_MAX_W = 8;

   typedef struct packed {
      logic                          sop;
      logic                          eop;
      logic [DISPATCH_PID_MAX_W-1:0] pid;
   } dispatch_pkt_hdr_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int calc_num_pkts(input int num_threads, input int num_lanes);
      return num_threads / num_lanes;
   endfunction

   function automatic int calc_pid_w(input int num_pkts);
      return clog2_min1(num_pkts);
   endfunction

endpackage

// File: rtl/vx_dispatch_packer_slicer.sv
// Finds the first, next and last non-empty lane slices of a thread mask.
module vx_dispatch_slicer
   import vx_gpu_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int NUM_LANES   = 2,
   parameter int NUM_PKTS    = calc_num_pkts(NUM_THREADS, NUM_LANES),
   parameter int PID_W       = calc_pid_w(NUM_PKTS)
) (
   input  logic [NUM_THREADS-1:0] tmask,
   input  logic [PID_W-1:0]       cur_pid,
   input  logic                   start,
   output logic [PID_W-1:0]       first_pid,
   output logic [PID_W-1:0]       next_pid,
   output logic                   is_last
);

   if (NUM_PKTS == 1) begin : g_single
      assign first_pid = '0;
      assign next_pid  = '0;
      assign is_last   = 1'b1;
   end else begin : g_split
      logic [NUM_PKTS-1:0] slice_nz;
      logic [PID_W-1:0]    beat_pid;
      logic                found_first;
      logic                found_next;

      for (genvar k = 0; k < NUM_PKTS; k++) begin : g_nz
         assign slice_nz[k] = |tmask[k*NUM_LANES +: NUM_LANES];
      end

      // An all-zero mask falls through to pid 0 and is_last, giving one empty beat.
      // NOTE: every output gets a default before the loops so no latch is inferred.
      always_comb begin
         first_pid   = '0;
         next_pid    = '0;
         is_last     = 1'b1;
         found_first = 1'b0;
         found_next  = 1'b0;
         for (int k = 0; k < NUM_PKTS; k++) begin
            if (slice_nz[k] && !found_first) begin
               first_pid   = PID_W'(k);
               found_first = 1'b1;
            end
            if (slice_nz[k] && !found_next && (k > int'(cur_pid))) begin
               next_pid   = PID_W'(k);
               found_next = 1'b1;
            end
         end
         beat_pid = start ? first_pid : next_pid;
         for (int k = 0; k < NUM_PKTS; k++) begin
            if (slice_nz[k] && (k > int'(beat_pid))) is_last = 1'b0;
         end
      end
   end

endmodule

// File: rtl/vx_dispatch_packer.sv
// Arbitrates dispatch channels onto one execution port, splitting each warp
// payload into lane-wide beats tagged with pid/sop/eop.
module vx_dispatch_packer
   import vx_gpu_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_THREADS = 4,
   parameter int NUM_LANES   = 2,
   parameter int XLEN        = 32,
   parameter int HDR_W       = 96,
   localparam int PID_W      = calc_pid_w(calc_num_pkts(NUM_THREADS, NUM_LANES)),
   localparam int SEL_W      = clog2_min1(NUM_INPUTS)
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_INPUTS-1:0]                in_valid,
   input  logic [NUM_INPUTS*HDR_W-1:0]          in_header,
   input  logic [NUM_INPUTS*NUM_THREADS-1:0]    in_tmask,
   input  logic [NUM_INPUTS*NUM_THREADS*3*XLEN-1:0] in_rs_data,
   output logic [NUM_INPUTS-1:0]                in_ready,
   output logic                                 out_valid,
   output logic [HDR_W-1:0]                     out_header,
   output logic [NUM_LANES-1:0]                 out_tmask,
   output logic [NUM_LANES*3*XLEN-1:0]          out_rs_data,
   output logic [PID_W-1:0]                     out_pid,
   output logic                                 out_sop,
   output logic                                 out_eop,
   output logic [SEL_W-1:0]                     out_sel,
   input  logic                                 out_ready
);

   localparam int THR_DW  = 3 * XLEN;
   localparam int IN_DW   = NUM_THREADS * THR_DW;
   localparam int BEAT_DW = NUM_LANES * THR_DW;

   logic [SEL_W-1:0]       rr_ptr, cur_sel, grant, sel, rr_next;
   logic                   lock;
   logic [PID_W-1:0]       cur_pid, first_pid, next_pid, beat_pid;
   logic                   any_valid, cand_valid, load, fire, beat_last;
   logic [NUM_THREADS-1:0] sel_tmask;
   int                     idx;

   // Round-robin pick, searching upward from rr_ptr with wrap-around.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      idx       = 0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_INPUTS;
         if (!any_valid && in_valid[idx]) begin
            any_valid = 1'b1;
            grant     = SEL_W'(idx);
         end
      end
   end

   assign sel        = lock ? cur_sel : grant;
   assign cand_valid = lock | any_valid;
   assign load       = !out_valid || out_ready;
   assign fire       = load && cand_valid;
   assign sel_tmask  = in_tmask[int'(sel)*NUM_THREADS +: NUM_THREADS];
   assign beat_pid   = lock ? next_pid : first_pid;
   assign rr_next    = (sel == SEL_W'(NUM_INPUTS-1)) ? '0 : sel + 1'b1;

   vx_dispatch_slicer #(
      .NUM_THREADS (NUM_THREADS),
      .NUM_LANES   (NUM_LANES)
   ) u_slicer (
      .tmask     (sel_tmask),
      .cur_pid   (cur_pid),
      .start     (!lock),
      .first_pid (first_pid),
      .next_pid  (next_pid),
      .is_last   (beat_last)
   );

   // The source is released only when its final beat enters the output register.
   always_comb begin
      in_ready = '0;
      if (fire && beat_last) in_ready[sel] = 1'b1;
   end

   // NOTE: header/operand registers are cleared too; cheap here and keeps reset state deterministic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid   <= 1'b0;
         out_header  <= '0;
         out_tmask   <= '0;
         out_rs_data <= '0;
         out_pid     <= '0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_sel     <= '0;
         rr_ptr      <= '0;
         cur_sel     <= '0;
         cur_pid     <= '0;
         lock        <= 1'b0;
      end else if (load) begin
         out_valid <= cand_valid;
         if (cand_valid) begin
            out_header  <= in_header[int'(sel)*HDR_W +: HDR_W];
            out_tmask   <= sel_tmask[int'(beat_pid)*NUM_LANES +: NUM_LANES];
            out_rs_data <= in_rs_data[int'(sel)*IN_DW + int'(beat_pid)*BEAT_DW +: BEAT_DW];
            out_pid     <= beat_pid;
            out_sop     <= !lock;
            out_eop     <= beat_last;
            out_sel     <= sel;
            if (beat_last) begin
               lock    <= 1'b0;
               cur_pid <= '0;
               rr_ptr  <= rr_next;
            end else begin
               lock    <= 1'b1;
               cur_sel <= sel;
               cur_pid <= beat_pid;
            end
         end
      end
   end

endmodule
